// File: rtl/y86_pkg.sv
// y86_pkg -- shared Y86-64 definitions for the write-back stage.
//
// Contents:
//   I_HALT..I_POPQ  4-bit instruction codes
//   R_RSP           stack-pointer register index (4)
//   R_NONE          "no register" specifier (4'hF)
//   stat_t          processor status encodings
//   wb_stat()       status derived from the sticky halt/illegal flags
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] R_RSP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef enum logic [2:0] {
      STAT_AOK = 3'd1,
      STAT_HLT = 3'd2,
      STAT_ADR = 3'd3,
      STAT_INS = 3'd4
   } stat_t;

   // An illegal instruction outranks halt when both have been seen.
   function automatic stat_t wb_stat(input logic halted, input logic err);
      if (err)
         return STAT_INS;
      else if (halted)
         return STAT_HLT;
      else
         return STAT_AOK;
   endfunction

endpackage

// File: rtl/wb_dst_decode.sv
// wb_dst_decode -- destination-register decode for the write-back stage.
//
// Purely combinational.
//   icode      in   instruction code
//   cnd        in   condition result (only used by cmovXX)
//   rA, rB     in   register specifiers from the instruction
//   dst_e      out  destination of valE (R_NONE = no write)
//   dst_m      out  destination of valM (R_NONE = no write)
//   is_halt    out  instruction is halt
//   is_illegal out  icode is outside the defined set (C..F)
module wb_dst_decode
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic       cnd,
   input  logic [3:0] rA,
   input  logic [3:0] rB,
   output logic [3:0] dst_e,
   output logic [3:0] dst_m,
   output logic       is_halt,
   output logic       is_illegal
);

   always_comb begin
      dst_e      = R_NONE;
      dst_m      = R_NONE;
      is_halt    = 1'b0;
      is_illegal = 1'b0;
      case (icode)
         I_HALT:                  is_halt = 1'b1;
         I_NOP, I_RMMOVQ, I_JXX:  ;
         I_CMOVXX:                dst_e = cnd ? rB : R_NONE;
         I_IRMOVQ, I_OPQ:         dst_e = rB;
         I_MRMOVQ:                dst_m = rA;
         I_CALL, I_RET, I_PUSHQ:  dst_e = R_RSP;
         I_POPQ: begin
            dst_e = R_RSP;
            dst_m = rA;
         end
         default:                 is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and architectural register file.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to forward same-cycle
// write data to the read ports. Without it, reads return the array
// contents as they were before the coming edge.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   wb_valid        a retiring instruction is presented this cycle
//   icode, cnd      instruction code and condition result
//   rA, rB          register specifiers (4'hF = none)
//   valE, valM      ALU result / memory read data
//   srcA, srcB      decode read addresses
//   valA, valB      combinational read data (0 for none / out of range)
//   reg_dump        all registers, R[i] at [i*DATA_W +: DATA_W]
//   retired         saturating count of accepted instructions
//   halted, err     sticky halt / illegal-instruction flags
//
// Handshake: wb_valid has no ready partner. An instruction presented with
// wb_valid high is accepted on that edge unless halt has already retired,
// in which case it is ignored until reset. There is never backpressure.
module wb_regfile
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREGS  = 15,
   parameter int CNT_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wb_valid,
   input  logic [3:0]              icode,
   input  logic                    cnd,
   input  logic [3:0]              rA,
   input  logic [3:0]              rB,
   input  logic [DATA_W-1:0]       valE,
   input  logic [DATA_W-1:0]       valM,
   input  logic [3:0]              srcA,
   input  logic [3:0]              srcB,
   output logic [DATA_W-1:0]       valA,
   output logic [DATA_W-1:0]       valB,
   output logic [NREGS*DATA_W-1:0] reg_dump,
   output logic [CNT_W-1:0]        retired,
   output logic                    halted,
   output logic                    err
);

   // Register indices are 4 bits; NREGS never exceeds 15, so R_NONE is
   // always out of range and a single compare drops both cases.
   localparam logic [3:0] NREGS_4 = 4'(NREGS);

   logic [DATA_W-1:0] regs [NREGS];

   logic [3:0] dst_e;
   logic [3:0] dst_m;
   logic       is_halt;
   logic       is_illegal;
   logic       accept;
   logic       we_e;
   logic       we_m;

   wb_dst_decode u_dst_decode (
      .icode      (icode),
      .cnd        (cnd),
      .rA         (rA),
      .rB         (rB),
      .dst_e      (dst_e),
      .dst_m      (dst_m),
      .is_halt    (is_halt),
      .is_illegal (is_illegal)
   );

   assign accept = wb_valid && !halted;
   assign we_e   = accept && (dst_e < NREGS_4);
   assign we_m   = accept && (dst_m < NREGS_4);

   // The M write is issued after the E write, so when both target the same
   // register the loaded value lands (popq %rsp).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         retired <= '0;
         halted  <= 1'b0;
         err     <= 1'b0;
      end else if (accept) begin
         for (int i = 0; i < NREGS; i++) begin
            if (we_e && (dst_e == 4'(i)))
               regs[i] <= valE;
            if (we_m && (dst_m == 4'(i)))
               regs[i] <= valM;
         end
         if (retired != {CNT_W{1'b1}})
            retired <= retired + CNT_W'(1);
         if (is_halt)
            halted <= 1'b1;
         if (is_illegal)
            err <= 1'b1;
      end
   end

   // Read ports: array value first, then (optionally) forwarded write data
   // with dstM taking priority over dstE.
   always_comb begin
      valA = '0;
      if (srcA < NREGS_4)
         valA = regs[srcA];
`ifdef WB_REGFILE_BYPASS_EN
      // rst_n gating keeps the ports at zero while reset is held even if
      // an instruction is still being presented.
      if (rst_n) begin
         if (we_e && (dst_e == srcA))
            valA = valE;
         if (we_m && (dst_m == srcA))
            valA = valM;
      end
`endif
   end

   always_comb begin
      valB = '0;
      if (srcB < NREGS_4)
         valB = regs[srcB];
`ifdef WB_REGFILE_BYPASS_EN
      if (rst_n) begin
         if (we_e && (dst_e == srcB))
            valB = valE;
         if (we_m && (dst_m == srcB))
            valB = valM;
      end
`endif
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_dump
      assign reg_dump[g*DATA_W +: DATA_W] = regs[g];
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- directed self-checking bench for wb_regfile.
module tb_wb_regfile;

   localparam int DATA_W = 64;
   localparam int NREGS  = 15;
   localparam int CNT_W  = 32;

   logic                    clk;
   logic                    rst_n;
   logic                    wb_valid;
   logic [3:0]              icode;
   logic                    cnd;
   logic [3:0]              rA;
   logic [3:0]              rB;
   logic [DATA_W-1:0]       valE;
   logic [DATA_W-1:0]       valM;
   logic [3:0]              srcA;
   logic [3:0]              srcB;
   logic [DATA_W-1:0]       valA;
   logic [DATA_W-1:0]       valB;
   logic [NREGS*DATA_W-1:0] reg_dump;
   logic [CNT_W-1:0]        retired;
   logic                    halted;
   logic                    err;

   int checks = 0;
   int errors = 0;

   // Hand-maintained expected register contents.
   logic [DATA_W-1:0] exp_r [NREGS];

   wb_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_valid (wb_valid),
      .icode    (icode),
      .cnd      (cnd),
      .rA       (rA),
      .rB       (rB),
      .valE     (valE),
      .valM     (valM),
      .srcA     (srcA),
      .srcB     (srcB),
      .valA     (valA),
      .valB     (valB),
      .reg_dump (reg_dump),
      .retired  (retired),
      .halted   (halted),
      .err      (err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dump(input string tag);
      for (int i = 0; i < NREGS; i++)
         check($sformatf("%s R%0d", tag, i), reg_dump[i*DATA_W +: DATA_W], exp_r[i]);
   endtask

   task automatic check_flags(input string tag, input logic [CNT_W-1:0] e_ret,
                              input logic e_halt, input logic e_err);
      check({tag, " retired"}, 64'(retired), 64'(e_ret));
      check({tag, " halted"}, 64'(halted), 64'(e_halt));
      check({tag, " err"}, 64'(err), 64'(e_err));
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NREGS; i++)
         exp_r[i] = '0;
   endtask

   // Present one instruction for one edge, then sample 1 time unit later.
   task automatic retire(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
      icode    = ic;
      cnd      = c;
      rA       = ra;
      rB       = rb;
      valE     = ve;
      valM     = vm;
      wb_valid = 1'b1;
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      wb_valid = 1'b0;
      icode    = 4'h1;
      cnd      = 1'b0;
      rA       = 4'hF;
      rB       = 4'hF;
      valE     = '0;
      valM     = '0;
      srcA     = 4'hF;
      srcB     = 4'hF;
      clear_exp();

      // Reset state
      #12;
      check_flags("reset", 0, 1'b0, 1'b0);
      check_dump("reset");
      check("reset valA", valA, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // irmovq rB=2
      retire(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0);
      exp_r[2] = 64'h1234;
      check_dump("irmovq");
      check_flags("irmovq", 1, 1'b0, 1'b0);
      srcA = 4'h2;
      srcB = 4'hF;
      #1;
      check("read R2 valA", valA, 64'h1234);
      check("read none valB", valB, 64'h0);

      // cmovXX not taken, then taken
      retire(4'h2, 1'b0, 4'hF, 4'h3, 64'hAA, 64'h0);
      check_dump("cmov nt");
      check_flags("cmov nt", 2, 1'b0, 1'b0);
      retire(4'h2, 1'b1, 4'hF, 4'h3, 64'hAA, 64'h0);
      exp_r[3] = 64'hAA;
      check_dump("cmov t");
      check_flags("cmov t", 3, 1'b0, 1'b0);

      // popq %rsp: M wins; popq %rcx: both written
      retire(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'hDEAD);
      exp_r[4] = 64'hDEAD;
      check_dump("popq rsp");
      retire(4'hB, 1'b0, 4'h1, 4'hF, 64'h100, 64'hDEAD);
      exp_r[4] = 64'h100;
      exp_r[1] = 64'hDEAD;
      check_dump("popq r1");
      check_flags("popq", 5, 1'b0, 1'b0);

      // mrmovq, ret, rmmovq, dropped destination
      retire(4'h5, 1'b0, 4'h7, 4'h2, 64'h999, 64'h77);
      exp_r[7] = 64'h77;
      retire(4'h9, 1'b0, 4'hF, 4'hF, 64'h200, 64'h0);
      exp_r[4] = 64'h200;
      retire(4'h4, 1'b0, 4'h1, 4'h2, 64'h5, 64'h6);
      retire(4'h3, 1'b0, 4'hF, 4'hF, 64'h33, 64'h0);
      check_dump("misc");
      check_flags("misc", 9, 1'b0, 1'b0);

      // wb_valid low: nothing changes
      icode = 4'h3;
      rB    = 4'h6;
      valE  = 64'hBAD;
      @(posedge clk);
      #1;
      check_dump("idle");
      check_flags("idle", 9, 1'b0, 1'b0);

      // Same-cycle read of a register being written
      srcA     = 4'h5;
      srcB     = 4'h4;
      icode    = 4'h3;
      cnd      = 1'b0;
      rA       = 4'hF;
      rB       = 4'h5;
      valE     = 64'h55;
      wb_valid = 1'b1;
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      check("same-cycle valA", valA, 64'h55);
`else
      check("same-cycle valA", valA, 64'h0);
`endif
      check("same-cycle valB", valB, 64'h200);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      exp_r[5] = 64'h55;
      check("next-cycle valA", valA, 64'h55);
      check_flags("bypass", 10, 1'b0, 1'b0);

      // R6 = 0x99, then asynchronous reset mid-write
      retire(4'h3, 1'b0, 4'hF, 4'h6, 64'h99, 64'h0);
      exp_r[6] = 64'h99;
      check_dump("r6");
      srcB     = 4'h6;
      icode    = 4'h3;
      rB       = 4'h6;
      valE     = 64'h1;
      wb_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      clear_exp();
      check_dump("async rst");
      check_flags("async rst", 0, 1'b0, 1'b0);
      check("async rst valA", valA, 64'h0);
      check("async rst valB", valB, 64'h0);
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      check_flags("held rst", 0, 1'b0, 1'b0);
      check("held rst valB", valB, 64'h0);
      rst_n = 1'b1;

      // Illegal, halt, then an ignored irmovq
      retire(4'hE, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
      check_flags("illegal", 1, 1'b0, 1'b1);
      retire(4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
      check_flags("halt", 2, 1'b1, 1'b1);
      retire(4'h3, 1'b0, 4'hF, 4'h0, 64'h7, 64'h0);
      check_flags("post-halt", 2, 1'b1, 1'b1);
      check_dump("post-halt");

      // Reset clears halt; err does not block later instructions
      #2;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      check_flags("rst2", 0, 1'b0, 1'b0);
      retire(4'hF, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
      retire(4'h3, 1'b0, 4'hF, 4'h8, 64'h88, 64'h0);
      exp_r[8] = 64'h88;
      check_dump("err-continue");
      check_flags("err-continue", 2, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
